// File: rtl/sha256_msg_scheduler.sv
// rtl/sha256_msg_scheduler.sv - SHA-256 message-schedule expansion for one 512-bit block
module sha256_msg_scheduler #(
    parameter int NUM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        msg_valid,
    input  logic [31:0] msg_word,
    output logic        msg_ready,
    output logic        w_valid,
    output logic [31:0] w_word,
    output logic [5:0]  w_index,
    input  logic        w_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] wbuf [16];

    logic        load_acc;
    logic        emit_acc;
    logic        last_word;
    logic [5:0]  nxt_idx;
    logic [3:0]  cur;
    logic [3:0]  slot;
    logic [31:0] w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign load_acc  = (state == S_LOAD) && msg_valid;
    assign emit_acc  = (state == S_EMIT) && w_ready;
    assign last_word = (w_index == LAST_IDX);
    assign nxt_idx   = w_index + 6'd1;
    assign cur       = w_index[3:0];
    assign slot      = nxt_idx[3:0];

    // The slot being overwritten still holds W[t-15] when read, giving the t-16 term
    assign w_new = sig1(wbuf[cur - 4'd1]) + wbuf[cur - 4'd6]
                 + sig0(wbuf[cur - 4'd14]) + wbuf[slot];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (load_acc && cnt == 4'd15) state_nxt = S_EMIT;
            S_EMIT:  if (emit_acc && last_word) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        msg_ready = 1'b0;
        w_valid   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_LOAD: begin
                msg_ready = 1'b1;
                busy      = 1'b1;
            end
            S_EMIT: begin
                w_valid = 1'b1;
                busy    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            w_word  <= 32'd0;
            w_index <= 6'd0;
        end else begin
            if (state == S_IDLE && start) begin
                cnt <= 4'd0;
            end else if (load_acc) begin
                cnt <= cnt + 4'd1;
            end

            if (load_acc && cnt == 4'd15) begin
                w_word  <= wbuf[0];
                w_index <= 6'd0;
            end else if (emit_acc && !last_word) begin
                w_index <= nxt_idx;
                w_word  <= (nxt_idx < 6'd16) ? wbuf[slot] : w_new;
            end
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset
    always_ff @(posedge clk) begin
        if (load_acc) begin
            wbuf[cnt] <= msg_word;
        end else if (emit_acc && !last_word && nxt_idx >= 6'd16) begin
            wbuf[slot] <= w_new;
        end
    end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// tb/tb_sha256_msg_scheduler.sv - directed bench for sha256_msg_scheduler
module tb_sha256_msg_scheduler;

    localparam int NUM = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        msg_valid;
    logic [31:0] msg_word;
    logic        w_ready;
    logic        msg_ready;
    logic        w_valid;
    logic [31:0] w_word;
    logic [5:0]  w_index;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [NUM];

    sha256_msg_scheduler #(.NUM_WORDS(NUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .msg_valid (msg_valid),
        .msg_word  (msg_word),
        .msg_ready (msg_ready),
        .w_valid   (w_valid),
        .w_word    (w_word),
        .w_index   (w_index),
        .w_ready   (w_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model();
        for (int t = 0; t < NUM; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[t];
            end else begin
                exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                         + exp_w[t-7]
                         + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                         + exp_w[t-16];
            end
        end
    endtask

    task automatic set_block(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w15);
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = w0;
        blk[1]  = w1;
        blk[15] = w15;
        build_model();
    endtask

    // Starts from IDLE at a negedge; returns at the negedge where W0 should be visible
    task automatic load_block(input bit gaps);
        msg_valid = 1'b1;
        msg_word  = 32'hdeadbeef;
        @(negedge clk);
        check("idle_msg_ready", {31'd0, msg_ready}, 32'd0);
        msg_valid = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_msg_ready", {31'd0, msg_ready}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (gaps && (i % 5 == 2)) begin
                msg_valid = 1'b0;
                start     = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("gap_msg_ready", {31'd0, msg_ready}, 32'd1);
                @(negedge clk);
            end
            msg_valid = 1'b1;
            msg_word  = blk[i];
            if (i == 15) check("w_valid_early", {31'd0, w_valid}, 32'd0);
            @(negedge clk);
        end
        msg_valid = 1'b0;
        msg_word  = 32'd0;
        check("w0_latency", {31'd0, w_valid}, 32'd1);
    endtask

    // mode 0: w_ready high; mode 1: 1 high / 3 low; mode 2: w_ready high plus start/msg_valid noise
    task automatic run_emit(input int mode, input int stop_at, input logic [31:0] exp16);
        int          idx = 0;
        int          cyc = 0;
        logic        rdy;
        logic        stalled = 1'b0;
        logic [31:0] pw = 32'd0;
        logic [5:0]  pi = 6'd0;
        while (idx < NUM && cyc < 1000) begin
            if (idx == stop_at) return;
            check("w_valid", {31'd0, w_valid}, 32'd1);
            if (!w_valid) break;
            check("w_index", {26'd0, w_index}, idx);
            check("w_word", w_word, exp_w[idx]);
            if (idx == 0 && !stalled) check("emit_busy", {31'd0, busy}, 32'd1);
            if (idx == 16 && !stalled) check("w16_hand", w_word, exp16);
            if (stalled) begin
                check("stall_word", w_word, pw);
                check("stall_index", {26'd0, w_index}, {26'd0, pi});
            end
            rdy     = (mode == 1) ? (cyc % 4 == 3) : 1'b1;
            w_ready = rdy;
            if (mode == 2 && (idx == 5 || idx == 30)) begin
                start     = 1'b1;
                msg_valid = 1'b1;
                msg_word  = 32'hdeadbeef;
                check("emit_msg_ready", {31'd0, msg_ready}, 32'd0);
            end else begin
                start     = 1'b0;
                msg_valid = 1'b0;
            end
            pw      = w_word;
            pi      = w_index;
            stalled = !rdy;
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        w_ready   = 1'b0;
        start     = 1'b0;
        msg_valid = 1'b0;
        check("emit_cycles", cyc, (mode == 1) ? 4 * NUM : NUM);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_w_valid", {31'd0, w_valid}, 32'd0);
        @(negedge clk);
        check("done_once", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_msg_ready"}, {31'd0, msg_ready}, 32'd0);
        check({tag, "_w_valid"}, {31'd0, w_valid}, 32'd0);
        check({tag, "_w_word"}, w_word, 32'd0);
        check({tag, "_w_index"}, {26'd0, w_index}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        msg_valid = 1'b0;
        msg_word  = 32'd0;
        w_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("release");

        // "abc" block
        set_block(32'h61626380, 32'd0, 32'h00000018);
        load_block(1'b0);
        run_emit(0, -1, 32'h61626380);

        // Single bit in W1
        set_block(32'd0, 32'd1, 32'd0);
        load_block(1'b0);
        run_emit(0, -1, 32'h02004000);

        // All-zero block
        set_block(32'd0, 32'd0, 32'd0);
        load_block(1'b0);
        run_emit(0, -1, 32'd0);

        // "abc" with a throttled consumer
        set_block(32'h61626380, 32'd0, 32'h00000018);
        load_block(1'b0);
        run_emit(1, -1, 32'h61626380);

        // Reset in the middle of emission, then a clean rerun
        load_block(1'b0);
        run_emit(0, 20, 32'h61626380);
        check("pre_reset_index", {26'd0, w_index}, 32'd20);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst     = 1'b0;
        w_ready = 1'b0;
        @(negedge clk);
        check_all_zero("postreset");
        load_block(1'b0);
        run_emit(0, -1, 32'h61626380);

        // Load gaps with stray start, then emission with stray start/msg_valid
        load_block(1'b1);
        run_emit(2, -1, 32'h61626380);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_scheduler.md
Name: sha256_msg_scheduler

Overview:
- Sequences the SHA-256 message-schedule expansion for one 512-bit block.
- Accepts the 16 block words W[0..15] over a valid/ready stream and stores them in a 16-entry circular buffer.
- Emits W[0..NUM_WORDS-1] one word per handshake, computing W[16+] in place using the rotate-right sigma functions.
- Sits between the block loader and the compression-round engine in the mining hash pipeline.

Parameters:
- NUM_WORDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a block; honoured only in IDLE.
- msg_valid  input  1  msg_word is valid.
- msg_word  input  32  block word, big-endian word order, W[0] first.
- msg_ready  output  1  scheduler accepts msg_word this cycle.
- w_valid  output  1  w_word/w_index are valid.
- w_word  output  32  schedule word W[w_index].
- w_index  output  6  index t of the current word, 0..NUM_WORDS-1.
- w_ready  input  1  consumer accepts w_word this cycle.
- busy  output  1  high in LOAD and EMIT.
- done  output  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Reset: asynchronous, active-high. While rst is high and on release: state=IDLE; msg_ready=0, w_valid=0, w_word=0, w_index=0, busy=0, done=0; load counter=0; buffer contents are don't-care.
- Reset mid-operation aborts the block. No partial output follows reset.
- Definitions:
  - rotr(x,n) = (x>>n) | (x<<(32-n)), 32-bit.
  - s0(x) = rotr(x,7) ^ rotr(x,18) ^ (x>>3).
  - s1(x) = rotr(x,17) ^ rotr(x,19) ^ (x>>10).
  - For t>=16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32, carries discarded.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - All handshake outputs low.
  - start=1 -> LOAD, load counter=0.
  - start in any other state is ignored.
- LOAD:
  - msg_ready=1 combinationally from the state.
  - Each msg_valid&msg_ready writes buf[cnt]=msg_word and increments cnt.
  - On the 16th accept -> EMIT. On that same edge: w_word<=buf[0] (if cnt was 0 this cycle, that is the word just accepted), w_index<=0, w_valid<=1.
  - Latency: W[0] is presented the cycle after the 16th word is accepted.
  - Gaps in msg_valid are legal; state and count hold.
- EMIT:
  - w_valid=1 throughout.
  - w_word and w_index are registered and must hold stable while w_ready=0.
  - On a handshake with w_index=t < NUM_WORDS-1:
    - w_index<=t+1.
    - If t+1<16: w_word<=buf[t+1].
    - Else: w_word<=W[t+1], computed from buf slots (t-1)%16, (t-6)%16, (t-14)%16, (t+1)%16 (old values), and buf[(t+1)%16]<=W[t+1] on the same edge.
    - Read-before-write on the same slot is required.
  - Handshake at t=NUM_WORDS-1 -> DONE, w_valid<=0.
  - Throughput: one word per cycle with w_ready held high. No bubbles, including across the 15->16 boundary.
- DONE: done=1 for exactly one cycle -> IDLE. busy is low in DONE.
- msg_valid outside LOAD is ignored; msg_ready is 0 there.
- w_ready outside EMIT is ignored.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000; 64 consecutive w_valid cycles; done pulses once; busy falls with done.
- W1=0x00000001, all others 0 -> W0..W15 echoed unchanged, then W16=0x02004000.
- All-zero block -> all 64 words 0x00000000; w_index steps 0..63 with no gaps.
- Toggle w_ready randomly (e.g. 1 cycle high, 3 low) on the "abc" block -> identical word sequence to the w_ready=1 run; w_word and w_index stable while w_ready=0.
- Assert rst for 1 cycle at w_index=20 -> all outputs 0 the same cycle; a fresh start plus reload of "abc" reproduces the full reference sequence.
- start pulsed during LOAD and EMIT; msg_valid driven during EMIT -> no state change, no extra words accepted or emitted; msg_valid gaps in LOAD delay W0 to exactly one cycle after the 16th accept.
